// File: rtl/conv_stream_if.sv
// Pixel/coefficient stream bundle for the KxK convolution engine.
// The producer (image source) uses master; the engine uses slave.
interface conv_stream_if #(
  parameter int IMG_NB      = 7,
  parameter int KERNEL_SIZE = 3,
  parameter int KERNEL_NB   = 8
);
  localparam int AW     = $clog2(KERNEL_SIZE * KERNEL_SIZE);
  localparam int OUT_NB = IMG_NB + KERNEL_NB + 1 + AW;

  logic                 i_valid;
  logic [IMG_NB-1:0]    i_pixel;
  logic                 i_k_we;
  logic [AW-1:0]        i_k_addr;
  logic [KERNEL_NB-1:0] i_k_data;
  logic                 o_valid;
  logic [OUT_NB-1:0]    o_pixel;
  logic                 o_last;

  modport master (
    output i_valid, i_pixel, i_k_we, i_k_addr, i_k_data,
    input  o_valid, o_pixel, o_last
  );

  modport slave (
    input  i_valid, i_pixel, i_k_we, i_k_addr, i_k_data,
    output o_valid, o_pixel, o_last
  );
endinterface

// File: rtl/conv_stream.sv
// Streaming KxK 2-D convolution: K-1 line buffers feed a KxK window,
// followed by a 3-stage multiply / row-sum / final-sum pipeline.
module conv_stream #(
  parameter int IMG_WIDTH   = 640,
  parameter int IMG_HEIGHT  = 480,
  parameter int IMG_NB      = 7,
  parameter int KERNEL_SIZE = 3,
  parameter int KERNEL_NB   = 8
) (
  input logic          clk100,
  input logic          in_reset,
  conv_stream_if.slave bus
);
  localparam int K       = KERNEL_SIZE;
  localparam int KK      = K * K;
  localparam int AW      = $clog2(KK);
  localparam int PROD_NB = IMG_NB + KERNEL_NB + 1;
  localparam int OUT_NB  = PROD_NB + AW;
  localparam int CW      = $clog2(IMG_WIDTH);
  localparam int RW      = $clog2(IMG_HEIGHT);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          col_end;
  logic          row_end;
  logic          first_px;
  logic          win_done;
  logic          win_last;

  assign col_end  = (col == CW'(IMG_WIDTH - 1));
  assign row_end  = (row == RW'(IMG_HEIGHT - 1));
  assign first_px = bus.i_valid && (row == '0) && (col == '0);
  assign win_done = bus.i_valid && (row >= RW'(K - 1)) && (col >= CW'(K - 1));
  assign win_last = win_done && row_end && col_end;

  logic signed [KERNEL_NB-1:0] shadow_k [KK];
  logic signed [KERNEL_NB-1:0] active_k [KK];

  logic [IMG_NB-1:0] line_buf [K-1][IMG_WIDTH];
  logic [IMG_NB-1:0] win      [K][K];
  logic [IMG_NB-1:0] col_vec  [K];

  logic signed [PROD_NB-1:0] prod    [KK];
  logic signed [OUT_NB-1:0]  row_acc [K];
  logic signed [OUT_NB-1:0]  row_sum [K];
  logic signed [OUT_NB-1:0]  total;

  logic win_v, win_l;
  logic prod_v, prod_l;
  logic sum_v, sum_l;
  logic out_valid, out_last;
  logic signed [OUT_NB-1:0] out_pixel;

  // Raster position plus the valid/last tags that ride alongside the datapath
  always_ff @(posedge clk100) begin
    if (!in_reset) begin
      col       <= '0;
      row       <= '0;
      win_v     <= 1'b0;
      win_l     <= 1'b0;
      prod_v    <= 1'b0;
      prod_l    <= 1'b0;
      sum_v     <= 1'b0;
      sum_l     <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_pixel <= '0;
    end else begin
      if (bus.i_valid) begin
        if (col_end) begin
          col <= '0;
          row <= row_end ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
      win_v     <= win_done;
      win_l     <= win_last;
      prod_v    <= win_v;
      prod_l    <= win_l;
      sum_v     <= prod_v;
      sum_l     <= prod_l;
      out_valid <= sum_v;
      out_last  <= sum_v && sum_l;
      if (sum_v) out_pixel <= total;
    end
  end

  // The bank swap reads shadow before this cycle's write, so a write on
  // the first pixel of a frame only takes effect in the next frame
  always_ff @(posedge clk100) begin
    if (!in_reset) begin
      for (int i = 0; i < KK; i++) begin
        shadow_k[i] <= '0;
        active_k[i] <= '0;
      end
    end else begin
      if (first_px) begin
        for (int i = 0; i < KK; i++) active_k[i] <= shadow_k[i];
      end
      if (bus.i_k_we && (int'(bus.i_k_addr) < KK)) begin
        shadow_k[bus.i_k_addr] <= bus.i_k_data;
      end
    end
  end

  // New window column: oldest buffered row on top, incoming pixel at bottom
  always_comb begin
    col_vec[K-1] = bus.i_pixel;
    for (int i = 0; i < K - 1; i++) col_vec[i] = line_buf[K-2-i][col];
  end

  always_ff @(posedge clk100) begin
    if (bus.i_valid) begin
      line_buf[0][col] <= bus.i_pixel;
      for (int i = 1; i < K - 1; i++) line_buf[i][col] <= line_buf[i-1][col];
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K - 1; j++) win[i][j] <= win[i][j+1];
        win[i][K-1] <= col_vec[i];
      end
    end
  end

  // Pixels are zero-extended by one bit so they multiply as non-negative signed values
  always_ff @(posedge clk100) begin
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        prod[i*K+j] <= PROD_NB'($signed({1'b0, win[i][j]})) * PROD_NB'(active_k[i*K+j]);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < K; i++) begin
      row_acc[i] = '0;
      for (int j = 0; j < K; j++) row_acc[i] = row_acc[i] + OUT_NB'(prod[i*K+j]);
    end
  end

  always_ff @(posedge clk100) begin
    for (int i = 0; i < K; i++) row_sum[i] <= row_acc[i];
  end

  always_comb begin
    total = '0;
    for (int i = 0; i < K; i++) total = total + row_sum[i];
  end

  assign bus.o_valid = out_valid;
  assign bus.o_last  = out_last;
  assign bus.o_pixel = out_pixel;
endmodule

// File: tb/tb_conv_stream.sv
// Scoreboard bench for conv_stream on a 5x4 image with a 3x3 kernel:
// stimulus queues hand-computed results, a negedge monitor checks them.
module tb_conv_stream;
  localparam int W      = 5;
  localparam int H      = 4;
  localparam int NB     = 7;
  localparam int K      = 3;
  localparam int KNB    = 8;
  localparam int OUT_NB = NB + KNB + 1 + $clog2(K * K);

  logic clk = 1'b0;
  logic in_reset;
  always #5 clk = ~clk;

  conv_stream_if #(.IMG_NB(NB), .KERNEL_SIZE(K), .KERNEL_NB(KNB)) bus ();

  conv_stream #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .IMG_NB(NB), .KERNEL_SIZE(K), .KERNEL_NB(KNB)
  ) dut (
    .clk100  (clk),
    .in_reset(in_reset),
    .bus     (bus)
  );

  typedef struct {
    int val;
    bit last;
    int due;
  } exp_t;

  exp_t sb[$];
  int   total    = 0;
  int   bad      = 0;
  int   edge_cnt = 0;

  int ident[9] = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
  int ones[9]  = '{default: 1};
  int negs[9]  = '{default: -128};

  int exp_id[6]    = '{6, 7, 8, 11, 12, 13};
  int exp_ones[6]  = '{default: 1143};
  int exp_negs[6]  = '{default: -146304};
  int exp_sum[6]   = '{54, 63, 72, 99, 108, 117};
  int exp_sum2[6]  = '{60, 70, 80, 110, 120, 130};

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic checkOutput(input string name, input logic signed [31:0] actual,
                             input logic signed [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Results leave the DUT after a posedge; the scoreboard samples them mid-cycle
  always @(negedge clk) begin
    exp_t e;
    if (in_reset === 1'b1 && bus.o_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_o_valid", bus.o_valid, 0);
      end else begin
        e = sb.pop_front();
        checkOutput("o_pixel", $signed(bus.o_pixel), e.val);
        checkOutput("o_last", bus.o_last, e.last);
        checkOutput("latency_edge", edge_cnt, e.due);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic writeKernel(input int kv[9]);
    for (int a = 0; a < 9; a++) begin
      bus.i_k_we   = 1'b1;
      bus.i_k_addr = 4'(a);
      bus.i_k_data = 8'(kv[a]);
      tick();
    end
    bus.i_k_we = 1'b0;
  endtask

  // One frame of pixels; expected results are queued as each window completes
  task automatic applyStimulus(input bit ramp, input int cval, input int exp_vals[6],
                               input int gap_pct, input int wr_idx, input bit wr_at0,
                               input int rst_idx);
    int k;
    int r;
    int c;
    exp_t e;
    k = 0;
    for (int p = 0; p < W * H; p++) begin
      r = p / W;
      c = p % W;
      if (p == rst_idx) begin
        bus.i_valid = 1'b0;
        in_reset    = 1'b0;
        tick();
        in_reset = 1'b1;
        checkOutput("rst_o_valid", bus.o_valid, 0);
        checkOutput("rst_o_last", bus.o_last, 0);
        checkOutput("rst_o_pixel", $signed(bus.o_pixel), 0);
        return;
      end
      if (p == wr_idx) begin
        bus.i_valid = 1'b0;
        writeKernel(ones);
      end
      for (int g = 0; g < 4 && $urandom_range(0, 99) < gap_pct; g++) begin
        bus.i_valid = 1'b0;
        tick();
      end
      bus.i_valid = 1'b1;
      bus.i_pixel = ramp ? 7'(p) : 7'(cval);
      if (p == 0 && wr_at0) begin
        bus.i_k_we   = 1'b1;
        bus.i_k_addr = 4'd4;
        bus.i_k_data = 8'd2;
      end
      if (rst_idx < 0 && r >= K - 1 && c >= K - 1) begin
        e.val  = exp_vals[k];
        e.last = (k == 5);
        e.due  = edge_cnt + 4;
        sb.push_back(e);
        k++;
      end
      tick();
      bus.i_valid = 1'b0;
      bus.i_k_we  = 1'b0;
    end
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 40 && sb.size() > 0; i++) tick();
    tick();
    tick();
    checkOutput("drain_pending", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    in_reset     = 1'b0;
    bus.i_valid  = 1'b0;
    bus.i_pixel  = '0;
    bus.i_k_we   = 1'b0;
    bus.i_k_addr = '0;
    bus.i_k_data = '0;
    repeat (3) tick();
    checkOutput("reset_o_valid", bus.o_valid, 0);
    checkOutput("reset_o_last", bus.o_last, 0);
    checkOutput("reset_o_pixel", $signed(bus.o_pixel), 0);
    in_reset = 1'b1;
    tick();

    $display("[TB] identity kernel, ramp");
    writeKernel(ident);
    applyStimulus(1'b1, 0, exp_id, 0, -1, 1'b0, -1);
    waitDrain();
    checkOutput("hold_o_pixel", $signed(bus.o_pixel), 13);
    checkOutput("hold_o_valid", bus.o_valid, 0);

    $display("[TB] all-ones kernel, flat 127");
    writeKernel(ones);
    applyStimulus(1'b0, 127, exp_ones, 0, -1, 1'b0, -1);
    waitDrain();

    $display("[TB] all -128 kernel, flat 127");
    writeKernel(negs);
    applyStimulus(1'b0, 127, exp_negs, 0, -1, 1'b0, -1);
    waitDrain();

    $display("[TB] identity kernel, ramp with input gaps");
    writeKernel(ident);
    applyStimulus(1'b1, 0, exp_id, 40, -1, 1'b0, -1);
    waitDrain();

    $display("[TB] coefficient update inside a frame");
    writeKernel(ident);
    applyStimulus(1'b1, 0, exp_id, 0, 10, 1'b0, -1);
    applyStimulus(1'b1, 0, exp_sum, 0, -1, 1'b1, -1);
    applyStimulus(1'b1, 0, exp_sum2, 0, -1, 1'b0, -1);
    waitDrain();

    $display("[TB] reset in the middle of a frame");
    writeKernel(ident);
    applyStimulus(1'b1, 0, exp_id, 0, -1, 1'b0, 15);
    repeat (6) tick();
    writeKernel(ident);
    applyStimulus(1'b1, 0, exp_id, 0, -1, 1'b0, -1);
    waitDrain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
